// File: rtl/lc3b_pipe_ctrl.sv
// lc3b_pipe_ctrl: central stall/flush scheduler for the five-stage LC-3b pipeline.
// It resolves data-memory waits, taken-branch redirects, fetch waits and
// load-use hazards in a single priority encoder. It also keeps saturating
// stall and redirect event counters for performance debug.
module lc3b_pipe_ctrl #(
    parameter int REG_W           = 3,
    parameter int CNT_W           = 16,
    parameter int REDIRECT_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_sr1,
    input  logic [REG_W-1:0] id_sr2,
    input  logic             id_sr2mux_sel,
    input  logic             id_uses_sr1,
    input  logic             id_uses_sr2,
    input  logic             ex_is_load,
    input  logic [REG_W-1:0] ex_dr,
    input  logic             imem_resp,
    input  logic             mem_dmem_req,
    input  logic             dmem_resp,
    input  logic             mem_br_taken,
    output logic             pc_load,
    output logic             stall_if_id,
    output logic             stall_id_ex,
    output logic             stall_ex_mem,
    output logic             stall_mem_wb,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             flush_ex_mem,
    output logic             flush_mem_wb,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] redirect_cnt
);

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        IWAIT    = 3'd1,
        DWAIT    = 3'd2,
        REDIRECT = 3'd3
    } state_t;

    state_t           state_q, state_d, eff_state;
    logic [2:0]       rcnt_q, rcnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] redirect_cnt_q, redirect_cnt_d;
    logic             data_wait, load_use, redirect_take;

    assign data_wait = mem_dmem_req && !dmem_resp;
    assign load_use  = ex_is_load &&
                       ((id_uses_sr1 && (ex_dr == id_sr1)) ||
                        (id_uses_sr2 && !id_sr2mux_sel && (ex_dr == id_sr2)));

    // Priority encoder: data wait, redirect (or pending countdown), fetch wait, load-use.
    always_comb begin
        state_d       = state_q;
        rcnt_d        = rcnt_q;
        redirect_take = 1'b0;
        pc_load       = 1'b1;
        stall_if_id   = 1'b0;
        stall_id_ex   = 1'b0;
        stall_ex_mem  = 1'b0;
        stall_mem_wb  = 1'b0;
        flush_if_id   = 1'b0;
        flush_id_ex   = 1'b0;
        flush_ex_mem  = 1'b0;
        flush_mem_wb  = 1'b0;
        // A DWAIT entered during a redirect countdown resumes that countdown
        // once the data access completes; otherwise it behaves as RUN.
        if (state_q == DWAIT)
            eff_state = (rcnt_q != 3'd0) ? REDIRECT : RUN;
        else
            eff_state = state_q;

        if (data_wait) begin
            pc_load      = 1'b0;
            stall_if_id  = 1'b1;
            stall_id_ex  = 1'b1;
            stall_ex_mem = 1'b1;
            flush_mem_wb = 1'b1;
            state_d      = DWAIT;
        end else if (eff_state == REDIRECT) begin
            // EX/MEM already holds a bubble, so a new taken branch is ignored here.
            pc_load     = imem_resp;
            flush_if_id = 1'b1;
            state_d     = REDIRECT;
            if (imem_resp) begin
                rcnt_d = rcnt_q - 3'd1;
                if (rcnt_q == 3'd1)
                    state_d = RUN;
            end
        end else if (mem_br_taken) begin
            flush_if_id   = 1'b1;
            flush_id_ex   = 1'b1;
            flush_ex_mem  = 1'b1;
            rcnt_d        = 3'(REDIRECT_CYCLES);
            redirect_take = 1'b1;
            state_d       = REDIRECT;
        end else if (!imem_resp) begin
            pc_load     = 1'b0;
            flush_if_id = 1'b1;
            state_d     = IWAIT;
        end else begin
            state_d = RUN;
            if (load_use) begin
                pc_load     = 1'b0;
                stall_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end
        end

        // While held in reset every register loads a bubble and the PC is frozen.
        if (!rst_n) begin
            pc_load      = 1'b0;
            stall_if_id  = 1'b0;
            stall_id_ex  = 1'b0;
            stall_ex_mem = 1'b0;
            stall_mem_wb = 1'b0;
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
            flush_mem_wb = 1'b1;
        end
    end

    // Saturating performance counters.
    always_comb begin
        stall_cnt_d    = stall_cnt_q;
        redirect_cnt_d = redirect_cnt_q;
        if (!pc_load && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 1'b1;
        if (redirect_take && (redirect_cnt_q != '1))
            redirect_cnt_d = redirect_cnt_q + 1'b1;
    end

    // State, countdown and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= RUN;
            rcnt_q         <= 3'd0;
            stall_cnt_q    <= '0;
            redirect_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            rcnt_q         <= rcnt_d;
            stall_cnt_q    <= stall_cnt_d;
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    assign state_o      = state_q;
    assign stall_cnt    = stall_cnt_q;
    assign redirect_cnt = redirect_cnt_q;

endmodule

// File: doc/lc3b_pipe_ctrl.md
Name: lc3b_pipe_ctrl

Overview:
- Central stall/flush scheduler for the five-stage LC-3b pipeline (IF, ID, EX, MEM, WB).
- Watches the ID-stage operands that the IF/ID register presents, the EX-stage load destination, instruction and data memory handshakes, and the MEM-stage branch resolution.
- Drives the per-register stall and flush controls plus the PC load enable, so hazards and memory waits are resolved in one place.
- Also keeps saturating stall and redirect event counters for performance debug.

Parameters:
REG_W, 3, register-specifier width (lc3b_reg)
CNT_W, 16, width of the performance counters
REDIRECT_CYCLES, 1, extra cycles the front end is flushed after a taken branch (1..7)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_sr1  in  REG_W  SR1 of the instruction in IF/ID
id_sr2  in  REG_W  SR2 of the instruction in IF/ID
id_sr2mux_sel  in  1  1 = immediate operand; SR2 is not read
id_uses_sr1  in  1  instruction in ID reads SR1
id_uses_sr2  in  1  instruction in ID reads SR2 (qualified by id_sr2mux_sel)
ex_is_load  in  1  instruction in EX is LDR/LDB/LDI
ex_dr  in  REG_W  destination of the instruction in EX
imem_resp  in  1  instruction fetch completes this cycle
mem_dmem_req  in  1  instruction in MEM accesses data memory
dmem_resp  in  1  data access completes this cycle
mem_br_taken  in  1  branch/jump resolved taken in MEM
pc_load  out  1  PC may update this cycle
stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb  out  1 each  hold the register
flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb  out  1 each  load a bubble (all-zero packet)
state_o  out  3  current FSM state, for debug
stall_cnt  out  CNT_W  cycles with pc_load = 0
redirect_cnt  out  CNT_W  taken-branch redirects accepted

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - state = RUN, counters = 0, redirect counter = 0.
  - While rst_n is low: all flush_* = 1, all stall_* = 0, pc_load = 0.
- State register and counters are registered. Outputs are combinational from the registered state and the current inputs, so stalls take effect in the same cycle.
- The default in RUN with no event is: pc_load = 1, all stall/flush = 0.
- States: RUN, IWAIT, DWAIT, REDIRECT. Evaluation priority: DWAIT condition, then redirect, then IWAIT, then load-use.
- Data wait: mem_dmem_req && !dmem_resp, evaluated in any state.
  - stall PC, IF/ID, ID/EX and EX/MEM; flush_mem_wb = 1.
  - Next state = DWAIT, and it stays there until dmem_resp.
  - On the dmem_resp cycle, outputs are normal and the next state = RUN.
  - A pending REDIRECT countdown is frozen, not lost, while in DWAIT.
- Redirect: mem_br_taken in RUN or IWAIT, with no data wait.
  - pc_load = 1; flush IF/ID, ID/EX and EX/MEM.
  - redirect_cnt increments; the counter loads REDIRECT_CYCLES; next state = REDIRECT.
- REDIRECT state:
  - pc_load = !imem_resp ? 0 : 1; flush_if_id = 1; the counter decrements on imem_resp.
  - At count 0, go to RUN.
  - A new mem_br_taken here is ignored, because EX/MEM already holds a bubble.
- Fetch wait: !imem_resp in RUN.
  - pc_load = 0, flush_if_id = 1, downstream advances.
  - Next state = IWAIT; return to RUN on imem_resp.
- Load-use: ex_is_load and either of these matches:
  - id_uses_sr1 && ex_dr == id_sr1, or
  - id_uses_sr2 && !id_sr2mux_sel && ex_dr == id_sr2.
  - Response: pc_load = 0, stall_if_id = 1, flush_id_ex = 1, for exactly one cycle (the load moves to MEM, so the condition clears). No state change.
- Counters:
  - stall_cnt increments on every cycle where rst_n = 1 and pc_load = 0.
  - Both counters saturate at all-ones and never wrap.
- A stall and a flush are never asserted together on the same register. Flush wins is not permitted; the encoder guarantees exclusivity.

Test Plan:
- Reset mid-DWAIT: drop rst_n for 1 cycle with mem_dmem_req = 1, dmem_resp = 0 -> state_o = RUN immediately, all flush_* = 1, counters = 0.
- Load-use: ex_is_load = 1, ex_dr = 3, id_sr1 = 3, id_uses_sr1 = 1 -> one cycle of pc_load = 0, stall_if_id = 1, flush_id_ex = 1. With id_sr2 = 3, id_sr2mux_sel = 1 and id_uses_sr1 = 0 -> no stall.
- Data miss: mem_dmem_req = 1, dmem_resp low for 4 cycles -> stall_if_id, stall_id_ex, stall_ex_mem = 1 and flush_mem_wb = 1 for 4 cycles; stall_cnt += 4; RUN on the 5th cycle.
- Branch taken with REDIRECT_CYCLES = 2, imem_resp every cycle -> flush IF/ID, ID/EX, EX/MEM in cycle 0; flush_if_id in cycles 1-2; RUN in cycle 3; redirect_cnt = 1.
- Simultaneous mem_br_taken and data wait -> DWAIT wins (no flush_ex_mem). The redirect is taken on the dmem_resp cycle.
- Saturation: preload via 65540 stall cycles (CNT_W = 16) -> stall_cnt holds at 16'hFFFF.
